// File: rtl/rp_reconfig_sequencer.sv
// -----------------------------------------------------------------------------
// rp_reconfig_sequencer
// Sequences partial reconfiguration of one reconfigurable partition. It drains
// the partition DMA FIFO, isolates the boundary, triggers the PRC with the
// requested module ID, holds the partition in reset for a fixed window and
// waits for the new module to report active before recoupling.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   req_reconfig      host request (honoured only in IDLE or ERROR)
//   req_id[7:0]       module ID captured with an accepted request
//   rp_fifo_empty     partition DMA FIFO empty
//   rp_active         partition reports active
//   prc_done          PRC load complete pulse
//   prc_error         PRC load failed pulse
//   prc_trigger       one-cycle load trigger to the PRC
//   prc_trigger_id    captured module ID presented with the trigger
//   decouple          boundary isolation enable
//   rst_prc_n         partition reset, active-low
//   busy              high outside IDLE and ERROR
//   status[2:0]       current state encoding
//   err_code[1:0]     00 none, 01 drain timeout, 10 PRC error, 11 active timeout
//   done              one-cycle pulse on successful completion
// -----------------------------------------------------------------------------
module rp_reconfig_sequencer #(
    parameter int unsigned DRAIN_TIMEOUT  = 65536,
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned ACTIVE_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_reconfig,
    input  logic [7:0] req_id,
    input  logic       rp_fifo_empty,
    input  logic       rp_active,
    input  logic       prc_done,
    input  logic       prc_error,
    output logic       prc_trigger,
    output logic [7:0] prc_trigger_id,
    output logic       decouple,
    output logic       rst_prc_n,
    output logic       busy,
    output logic [2:0] status,
    output logic [1:0] err_code,
    output logic       done
);

    localparam int unsigned ID_W      = 8;
    localparam int unsigned MAX_A     = (DRAIN_TIMEOUT > RESET_CYCLES) ? DRAIN_TIMEOUT : RESET_CYCLES;
    localparam int unsigned MAX_P     = (MAX_A > ACTIVE_TIMEOUT) ? MAX_A : ACTIVE_TIMEOUT;
    localparam int unsigned CNT_W     = $clog2(MAX_P) + 1;
    localparam int unsigned RUN_W     = 3;
    localparam int unsigned DRAIN_RUN = 4;

    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DECPL_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LAST  = CNT_W'(ACTIVE_TIMEOUT - 1);
    localparam logic [RUN_W-1:0] RUN_LAST     = RUN_W'(DRAIN_RUN - 1);

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_DRAIN  = 2'b01;
    localparam logic [1:0] ERR_PRC    = 2'b10;
    localparam logic [1:0] ERR_ACTIVE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_DRAIN       = 3'd1,
        S_DECOUPLE    = 3'd2,
        S_LOAD        = 3'd3,
        S_RESET       = 3'd4,
        S_WAIT_ACTIVE = 3'd5,
        S_ERROR       = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [1:0]        err_q, err_d;
    logic              trig_q, trig_d;
    logic              decouple_q, decouple_d;
    logic              rst_prc_n_q, rst_prc_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drain_ok;

    // Four consecutive empty samples inside DRAIN: three counted plus this one
    assign drain_ok = (state_q == S_DRAIN) && rp_fifo_empty && (run_q == RUN_LAST);

    // Next-state, counters and registered-output values
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_reconfig) begin
                    state_d = S_DRAIN;
                    id_d    = req_id;
                    err_d   = ERR_NONE;
                end
            end
            S_DRAIN: begin
                if (drain_ok) begin
                    state_d = S_DECOUPLE;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DECOUPLE;
                    err_d   = ERR_DRAIN;
                end
            end
            S_DECOUPLE: begin
                if (cnt_q == DECPL_LAST) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // A failure report wins over a simultaneous completion
                if (prc_error) begin
                    state_d = S_ERROR;
                    err_d   = ERR_PRC;
                end else if (prc_done) begin
                    state_d = S_RESET;
                end
            end
            S_RESET: begin
                if (cnt_q == RESET_LAST) begin
                    state_d = S_WAIT_ACTIVE;
                end
            end
            S_WAIT_ACTIVE: begin
                if (rp_active) begin
                    state_d = S_IDLE;
                end else if (cnt_q == ACTIVE_LAST) begin
                    state_d = S_ERROR;
                    err_d   = ERR_ACTIVE;
                end
            end
            S_ERROR: begin
                // Partition is already isolated, so the drain is skipped
                if (req_reconfig) begin
                    state_d = S_DECOUPLE;
                    id_d    = req_id;
                    err_d   = ERR_NONE;
                end
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase

        // Dwell counter: cleared on every state entry, saturating otherwise
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Empty-run counter only advances while draining
        run_d = '0;
        if ((state_q == S_DRAIN) && (state_d == S_DRAIN) && rp_fifo_empty) begin
            run_d = (run_q == RUN_LAST) ? run_q : run_q + RUN_W'(1);
        end

        decouple_d  = !((state_d == S_IDLE) || (state_d == S_DRAIN));
        rst_prc_n_d = (state_d == S_IDLE) || (state_d == S_DRAIN) || (state_d == S_WAIT_ACTIVE);
        busy_d      = !((state_d == S_IDLE) || (state_d == S_ERROR));
        trig_d      = (state_d == S_LOAD) && (state_q != S_LOAD);
        done_d      = (state_q == S_WAIT_ACTIVE) && (state_d == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RESET;
            cnt_q       <= '0;
            run_q       <= '0;
            id_q        <= '0;
            err_q       <= ERR_NONE;
            trig_q      <= 1'b0;
            decouple_q  <= 1'b1;
            rst_prc_n_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            id_q        <= id_d;
            err_q       <= err_d;
            trig_q      <= trig_d;
            decouple_q  <= decouple_d;
            rst_prc_n_q <= rst_prc_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign prc_trigger    = trig_q;
    assign prc_trigger_id = id_q;
    assign decouple       = decouple_q;
    assign rst_prc_n      = rst_prc_n_q;
    assign busy           = busy_q;
    assign status         = 3'(state_q);
    assign err_code       = err_q;
    assign done           = done_q;

endmodule

// File: tb/tb_rp_reconfig_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rp_reconfig_sequencer
// Directed scenarios followed by randomized traffic; every cycle the DUT
// outputs are compared with a phase/countdown reference model of the
// sequencer, plus explicit latency checks against fixed expected values.
// -----------------------------------------------------------------------------
module tb_rp_reconfig_sequencer;

    localparam int DRAIN_TIMEOUT  = 64;
    localparam int RESET_CYCLES   = 16;
    localparam int ACTIVE_TIMEOUT = 32;

    localparam int ST_IDLE   = 0;
    localparam int ST_DRAIN  = 1;
    localparam int ST_DECPL  = 2;
    localparam int ST_LOAD   = 3;
    localparam int ST_RESET  = 4;
    localparam int ST_WAIT   = 5;
    localparam int ST_ERROR  = 6;

    logic       clk;
    logic       r_rst, r_req, r_fe, r_act, r_pd, r_pe;
    logic [7:0] r_id;
    logic       prc_trigger, decouple, rst_prc_n, busy, done;
    logic [7:0] prc_trigger_id;
    logic [2:0] status;
    logic [1:0] err_code;

    rp_reconfig_sequencer #(
        .DRAIN_TIMEOUT  (DRAIN_TIMEOUT),
        .RESET_CYCLES   (RESET_CYCLES),
        .ACTIVE_TIMEOUT (ACTIVE_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (r_rst),
        .req_reconfig   (r_req),
        .req_id         (r_id),
        .rp_fifo_empty  (r_fe),
        .rp_active      (r_act),
        .prc_done       (r_pd),
        .prc_error      (r_pe),
        .prc_trigger    (prc_trigger),
        .prc_trigger_id (prc_trigger_id),
        .decouple       (decouple),
        .rst_prc_n      (rst_prc_n),
        .busy           (busy),
        .status         (status),
        .err_code       (err_code),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase, cycles left in a timed phase, empty run length
    int         m_st;
    int         m_left;
    int         m_run;
    logic [7:0] m_id;
    logic [1:0] m_err;
    logic       m_trig;
    logic       m_done;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dwell(input int s);
        case (s)
            ST_DRAIN: return DRAIN_TIMEOUT;
            ST_DECPL: return 2;
            ST_RESET: return RESET_CYCLES;
            ST_WAIT:  return ACTIVE_TIMEOUT;
            default:  return 0;
        endcase
    endfunction

    function automatic logic exp_decouple(input int s);
        return !(s == ST_IDLE || s == ST_DRAIN);
    endfunction

    function automatic logic exp_rstn(input int s);
        return (s == ST_IDLE || s == ST_DRAIN || s == ST_WAIT);
    endfunction

    function automatic logic exp_busy(input int s);
        return !(s == ST_IDLE || s == ST_ERROR);
    endfunction

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        int nx;
        m_trig = 1'b0;
        m_done = 1'b0;
        if (r_rst) begin
            m_st   = ST_RESET;
            m_left = RESET_CYCLES;
            m_id   = 8'h00;
            m_err  = 2'd0;
            m_run  = 0;
            return;
        end
        nx = m_st;
        case (m_st)
            ST_IDLE: if (r_req) begin
                nx = ST_DRAIN; m_id = r_id; m_err = 2'd0;
            end
            ST_DRAIN: begin
                m_run = r_fe ? m_run + 1 : 0;
                if (m_run == 4) nx = ST_DECPL;
                else if (m_left == 1) begin nx = ST_DECPL; m_err = 2'd1; end
            end
            ST_DECPL: if (m_left == 1) nx = ST_LOAD;
            ST_LOAD: begin
                if (r_pe) begin nx = ST_ERROR; m_err = 2'd2; end
                else if (r_pd) nx = ST_RESET;
            end
            ST_RESET: if (m_left == 1) nx = ST_WAIT;
            ST_WAIT: begin
                if (r_act) begin nx = ST_IDLE; m_done = 1'b1; end
                else if (m_left == 1) begin nx = ST_ERROR; m_err = 2'd3; end
            end
            ST_ERROR: if (r_req) begin
                nx = ST_DECPL; m_id = r_id; m_err = 2'd0;
            end
            default: nx = m_st;
        endcase
        if (nx != m_st) begin
            m_st   = nx;
            m_left = dwell(nx);
            m_run  = 0;
            if (nx == ST_LOAD) m_trig = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
        end
    endtask

    task automatic check_outputs();
        chk_eq("status",   32'(status),         32'(m_st));
        chk_eq("decouple", 32'(decouple),       32'(exp_decouple(m_st)));
        chk_eq("rst_prc_n",32'(rst_prc_n),      32'(exp_rstn(m_st)));
        chk_eq("busy",     32'(busy),           32'(exp_busy(m_st)));
        chk_eq("trigger",  32'(prc_trigger),    32'(m_trig));
        chk_eq("trig_id",  32'(prc_trigger_id), 32'(m_id));
        chk_eq("err_code", 32'(err_code),       32'(m_err));
        chk_eq("done",     32'(done),           32'(m_done));
    endtask

    // One clock: model update, edge, then sample on the falling edge
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_trigger(output int n, input int start);
        n = start;
        while (prc_trigger !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Complete a LOAD with prc_done after gap cycles; return reset-low length
    task automatic finish_load(input int gap, output int low_len);
        r_pd = 1'b0;
        repeat (gap) tick();
        r_pd = 1'b1;
        tick();
        r_pd = 1'b0;
        low_len = 0;
        while (rst_prc_n !== 1'b1 && low_len < 100) begin
            low_len++;
            tick();
        end
    endtask

    initial begin
        int n;
        int done_seen;

        r_rst = 1'b1; r_req = 1'b0; r_id = 8'h00; r_fe = 1'b1;
        r_act = 1'b0; r_pd = 1'b0; r_pe = 1'b0;
        m_st = ST_RESET; m_left = RESET_CYCLES; m_run = 0;
        m_id = 8'h00; m_err = 2'd0; m_trig = 1'b0; m_done = 1'b0;

        // Power-up
        repeat (4) tick();
        r_rst = 1'b0;
        n = 0;
        while (rst_prc_n !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk_eq("pwrup_rstn_delay", 32'(n), 32'(RESET_CYCLES));
        repeat (8) tick();
        r_act = 1'b1;
        tick();
        r_act = 1'b0;
        chk_eq("pwrup_done", 32'(done), 32'd1);
        chk_eq("pwrup_idle", 32'(status), 32'(ST_IDLE));

        // Nominal reconfiguration with ID 0x05
        r_req = 1'b1; r_id = 8'h05;
        tick();
        r_req = 1'b0; r_id = 8'h00;
        wait_trigger(n, 1);
        chk_eq("nom_trig_cycle", 32'(n), 32'd7);
        chk_eq("nom_trig_id", 32'(prc_trigger_id), 32'h05);
        finish_load(20, n);
        chk_eq("nom_reset_len", 32'(n), 32'(RESET_CYCLES));
        repeat (5) tick();
        r_act = 1'b1;
        tick();
        r_act = 1'b0;
        chk_eq("nom_done", 32'(done), 32'd1);
        chk_eq("nom_recouple", 32'(decouple), 32'd0);
        chk_eq("nom_err", 32'(err_code), 32'd0);

        // Drain timeout
        r_fe = 1'b0; r_req = 1'b1; r_id = 8'($urandom);
        tick();
        r_req = 1'b0;
        n = 1;
        while (decouple !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk_eq("drain_to_cycle", 32'(n), 32'(DRAIN_TIMEOUT + 1));
        chk_eq("drain_to_err", 32'(err_code), 32'd1);
        r_fe = 1'b1;
        wait_trigger(n, 0);
        finish_load(3, n);
        r_act = 1'b1;
        tick();
        r_act = 1'b0;
        chk_eq("drain_to_done", 32'(done), 32'd1);

        // PRC failure with simultaneous done/error, then recovery request
        r_req = 1'b1; r_id = 8'($urandom);
        tick();
        r_req = 1'b0;
        wait_trigger(n, 1);
        tick();
        r_pd = 1'b1; r_pe = 1'b1;
        tick();
        r_pd = 1'b0; r_pe = 1'b0;
        chk_eq("prcerr_status", 32'(status), 32'(ST_ERROR));
        chk_eq("prcerr_code", 32'(err_code), 32'd2);
        chk_eq("prcerr_decouple", 32'(decouple), 32'd1);
        chk_eq("prcerr_rstn", 32'(rst_prc_n), 32'd0);
        r_req = 1'b1; r_id = 8'h07;
        tick();
        r_req = 1'b0;
        chk_eq("retry_skip_drain", 32'(status), 32'(ST_DECPL));
        wait_trigger(n, 1);
        chk_eq("retry_trig_cycle", 32'(n), 32'd3);
        chk_eq("retry_trig_id", 32'(prc_trigger_id), 32'h07);

        // Active timeout
        finish_load(2, n);
        n = 0;
        done_seen = 0;
        while (status !== 3'(ST_ERROR) && n < 100) begin
            tick();
            n++;
            if (done === 1'b1) done_seen++;
        end
        chk_eq("act_to_cycles", 32'(n), 32'(ACTIVE_TIMEOUT));
        chk_eq("act_to_err", 32'(err_code), 32'd3);
        chk_eq("act_to_no_done", 32'(done_seen), 32'd0);

        // Request ignored during LOAD, then reset asserted in RESET
        r_req = 1'b1; r_id = 8'h33;
        tick();
        r_req = 1'b0;
        wait_trigger(n, 1);
        tick();
        r_req = 1'b1; r_id = 8'h99;
        tick();
        r_req = 1'b0;
        chk_eq("busy_req_status", 32'(status), 32'(ST_LOAD));
        chk_eq("busy_req_id", 32'(prc_trigger_id), 32'h33);
        r_pd = 1'b1;
        tick();
        r_pd = 1'b0;
        repeat (5) tick();
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        chk_eq("midrst_status", 32'(status), 32'(ST_RESET));
        chk_eq("midrst_id", 32'(prc_trigger_id), 32'h00);
        n = 0;
        while (rst_prc_n !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk_eq("midrst_bringup", 32'(n), 32'(RESET_CYCLES));
        r_act = 1'b1;
        tick();
        r_act = 1'b0;
        chk_eq("midrst_done", 32'(done), 32'd1);

        // Randomized traffic, with periodic stretches of a stuck-full FIFO
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 499) == 0);
            r_req = ($urandom_range(0, 5) == 0);
            r_id  = 8'($urandom);
            r_fe  = (((i / 250) % 3) == 2) ? ($urandom_range(0, 9) == 0)
                                           : ($urandom_range(0, 9) != 0);
            r_act = ($urandom_range(0, 7) == 0);
            r_pd  = ($urandom_range(0, 11) == 0);
            r_pe  = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
